align_ctrl: RTL and testbench
=============================

ALIGN_CTRL -- requirements
Module: align_ctrl

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  input  1  request alignment; sampled only in IDLE.
REQ-004 SHALL have: abort  input  1  cancel operation in progress.
REQ-005 SHALL have: exp_a  input  8  exponent of operand A.
REQ-006 SHALL have: exp_b  input  8  exponent of operand B.
REQ-007 SHALL have: sr_lsb  input  1  bit 0 of the driven 24-bit right-shift register's data_out.
REQ-008 SHALL have: sel  output  1  mantissa mux select into the shift register; 0 = A, 1 = B.
REQ-009 SHALL have: f_bit  output  1  hidden bit (F) presented with the load.
REQ-010 SHALL have: load, shift, clear  output  1 each  one-hot-or-zero controls to the shift register.
REQ-011 SHALL have: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have: done  output  1  one-cycle pulse, result valid.
REQ-013 SHALL have: exp_res  output  8  larger exponent.
REQ-014 SHALL have: sticky  output  1  OR of all bits shifted out.

Function
REQ-015 FSM SHALL have states IDLE, LOAD, SHIFT, DONE.
REQ-016 In IDLE with start=1: SHALL latch exp_a and exp_b, and compute diff = |exp_a - exp_b|, 8-bit unsigned.
REQ-017 In that same IDLE-with-start cycle: SHALL compute sel = (exp_a >= exp_b), so the smaller-exponent operand is loaded; on a tie, B is loaded.
REQ-018 In that same cycle: SHALL compute cnt = min(diff, 24), then go to LOAD.
REQ-019 LOAD: SHALL assert load=1 for exactly one cycle with f_bit = (smaller exponent != 0) and clear sticky; next state is SHIFT if cnt != 0, else DONE.
REQ-020 SHIFT: SHALL assert shift=1 each cycle, set sticky |= sr_lsb, decrement cnt, and go to DONE after the cycle in which cnt reaches 0.
REQ-021 DONE: SHALL assert done=1 for one cycle, hold exp_res = max(exp_a, exp_b) and sticky stable, then go to IDLE.
REQ-022 Latency: SHALL be start-to-done = min(diff, 24) + 2 cycles.
REQ-023 Outputs exp_res and sticky SHALL hold their last values while in IDLE, until the next LOAD.
REQ-024 sel SHALL remain stable from LOAD through DONE.
REQ-025 start while busy=1 SHALL be ignored, not queued.
REQ-026 abort=1 in LOAD, SHIFT or DONE SHALL, on that cycle, assert clear=1 and suppress load, shift and done, then go to IDLE with sticky=0.
REQ-027 abort has priority over all other transitions; abort in IDLE SHALL be ignored.
REQ-028 At most one of load, shift, clear SHALL be high in any cycle.
REQ-029 diff >= 24 SHALL saturate at 24 shifts: the register is then zero and sticky reflects the entire original mantissa.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, cnt=0, and all outputs 0 (sel, f_bit, load, shift, clear, busy, done, exp_res=8'h00, sticky).
REQ-031 Reset asserted mid-operation SHALL discard the operation with no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro ALIGN_STICKY_EN defined: sticky SHALL behave per REQ-020/REQ-026.
REQ-034 Macro ALIGN_STICKY_EN undefined: sticky SHALL be tied 0, sr_lsb ignored, and no sticky flop synthesized; all other behaviour unchanged.

Structure
REQ-035 A shared package align_pkg SHALL hold the state enum, EXP_W=8, MANT_W=24 and MAX_SHIFT=24.
REQ-036 Sub-module align_cnt SHALL be the 5-bit loadable down-counter with a zero flag, instantiated once; the shift register itself is instantiated by the parent, not here.

Verification
REQ-037 Scenario 1: exp_a=8'h85, exp_b=8'h82, start -> sel=1, load at cycle 1, shift on cycles 2-4, done at cycle 5, exp_res=8'h85.
REQ-038 Scenario 2: exp_a=exp_b=8'h7F -> sel=1, zero shifts, done at cycle 2, sticky=0.
REQ-039 Scenario 3: exp_a=8'h10, exp_b=8'hF0 -> sel=0, 24 shifts, done at cycle 26, exp_res=8'hF0.
REQ-040 Scenario 4: sr_lsb=1 on the 2nd of 3 shifts, ALIGN_STICKY_EN defined -> sticky=1 at done; with the macro undefined, sticky=0.
REQ-041 Scenario 5: abort in the 2nd SHIFT cycle -> clear=1 that cycle, no done, busy=0 next cycle; start while busy is ignored.
REQ-042 Scenario 6: rst_n low mid-SHIFT -> all outputs 0 immediately; new start after release completes normally.

Source files
------------

// File: rtl/align_pkg.sv
// Shared types and widths for the exponent-alignment controller.
package align_pkg;

    localparam int unsigned EXP_W     = 8;
    localparam int unsigned MANT_W    = 24;
    localparam int unsigned MAX_SHIFT = 24;
    localparam int unsigned CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Shift count saturates at the mantissa width: beyond that every bit is already gone.
    function automatic logic [CNT_W-1:0] sat_shift(input logic [EXP_W-1:0] d);
        if (d >= EXP_W'(MAX_SHIFT)) begin
            return CNT_W'(MAX_SHIFT);
        end
        return d[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/align_cnt.sv
// Loadable down-counter holding the number of right shifts still to perform.
module align_cnt
    import align_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_val,
    input  logic             dec,
    output logic             zero_c,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; decrement never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (ld) begin
            cnt_d = ld_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_c = (cnt_q == '0);
    assign last_c = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/align_ctrl.sv
// Exponent-alignment controller: loads the smaller-exponent mantissa into an
// external right-shift register and shifts it by the exponent difference.
// Build option: define ALIGN_STICKY_EN to track the sticky bit from sr_lsb;
// without it sticky is tied low and sr_lsb is ignored.
module align_ctrl
    import align_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             sr_lsb,
    output logic             sel,
    output logic             f_bit,
    output logic             load,
    output logic             shift,
    output logic             clear,
    output logic             busy,
    output logic             done,
    output logic [EXP_W-1:0] exp_res,
    output logic             sticky
);

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic             f_bit_q, f_bit_d;
    logic             busy_q, busy_d;
    logic [EXP_W-1:0] exp_res_q, exp_res_d;

    logic             a_ge_b_c;
    logic [EXP_W-1:0] diff_c;
    logic [EXP_W-1:0] small_c;

    logic             cnt_ld_c;
    logic [CNT_W-1:0] cnt_val_c;
    logic             cnt_dec_c;
    logic             cnt_zero_c;
    logic             cnt_last_c;

    logic             sticky_clr_c;
    logic             sticky_acc_c;

    // Operand compare; a tie selects B so the "smaller" side is always B then.
    always_comb begin
        a_ge_b_c = (exp_a >= exp_b);
        diff_c   = a_ge_b_c ? (exp_a - exp_b) : (exp_b - exp_a);
        small_c  = a_ge_b_c ? exp_b : exp_a;
    end

    align_cnt u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld     (cnt_ld_c),
        .ld_val (cnt_val_c),
        .dec    (cnt_dec_c),
        .zero_c (cnt_zero_c),
        .last_c (cnt_last_c)
    );

    // Next state, held operand info and shift-register strobes; abort wins everywhere but IDLE.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        f_bit_d      = f_bit_q;
        exp_res_d    = exp_res_q;
        cnt_ld_c     = 1'b0;
        cnt_val_c    = '0;
        cnt_dec_c    = 1'b0;
        sticky_clr_c = 1'b0;
        sticky_acc_c = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        clear        = 1'b0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    sel_d        = a_ge_b_c;
                    exp_res_d    = a_ge_b_c ? exp_a : exp_b;
                    f_bit_d      = (small_c != '0);
                    cnt_ld_c     = 1'b1;
                    cnt_val_c    = sat_shift(diff_c);
                    sticky_clr_c = 1'b1;
                end
            end
            LOAD, SHIFT, DONE: begin
                if (abort) begin
                    state_d      = IDLE;
                    clear        = 1'b1;
                    cnt_ld_c     = 1'b1;
                    sticky_clr_c = 1'b1;
                end else if (state_q == LOAD) begin
                    load    = 1'b1;
                    state_d = cnt_zero_c ? DONE : SHIFT;
                end else if (state_q == SHIFT) begin
                    shift        = 1'b1;
                    cnt_dec_c    = 1'b1;
                    sticky_acc_c = 1'b1;
                    if (cnt_last_c || cnt_zero_c) begin
                        state_d = DONE;
                    end
                end else begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Control state and held outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= 1'b0;
            f_bit_q   <= 1'b0;
            busy_q    <= 1'b0;
            exp_res_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            f_bit_q   <= f_bit_d;
            busy_q    <= busy_d;
            exp_res_q <= exp_res_d;
        end
    end

    assign sel     = sel_q;
    assign f_bit   = f_bit_q;
    assign busy    = busy_q;
    assign exp_res = exp_res_q;

`ifdef ALIGN_STICKY_EN
    logic sticky_q, sticky_d;

    // Sticky collects every bit that falls off the bottom of the shift register.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr_c) begin
            sticky_d = 1'b0;
        end else if (sticky_acc_c) begin
            sticky_d = sticky_q | sr_lsb;
        end
    end

    // Sticky register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`else
    logic unused_sticky;
    assign unused_sticky = sr_lsb ^ sticky_clr_c ^ sticky_acc_c;
    assign sticky        = 1'b0;
`endif

endmodule

// File: tb/tb_align_ctrl.sv
// Self-checking bench for align_ctrl: transaction-level reference model plus directed scenarios.
module tb_align_ctrl;

`ifdef ALIGN_STICKY_EN
    localparam bit STICKY_EN = 1'b1;
`else
    localparam bit STICKY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       sr_lsb = 1'b0;
    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_b = 8'h00;

    logic       sel, f_bit, load, shift, clear, busy, done, sticky;
    logic [7:0] exp_res;

    int checks = 0;
    int failures = 0;
    bit run_chk = 1'b0;

    align_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .exp_a   (exp_a),
        .exp_b   (exp_b),
        .sr_lsb  (sr_lsb),
        .sel     (sel),
        .f_bit   (f_bit),
        .load    (load),
        .shift   (shift),
        .clear   (clear),
        .busy    (busy),
        .done    (done),
        .exp_res (exp_res),
        .sticky  (sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the current transaction (0 = idle),
    // k=1 is the load cycle, k=2..n+1 the shifts, k=n+2 the done cycle.
    int         m_k = 0;
    int         m_n = 0;
    logic       m_sel = 1'b0;
    logic       m_f = 1'b0;
    logic       m_sticky = 1'b0;
    logic [7:0] m_exp = 8'h00;

    function automatic int shifts_for(input logic [7:0] a, input logic [7:0] b);
        int d;
        d = int'(a) - int'(b);
        if (d < 0) d = -d;
        return (d > 24) ? 24 : d;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_k <= 0; m_n <= 0; m_sel <= 1'b0; m_f <= 1'b0; m_sticky <= 1'b0; m_exp <= 8'h00;
        end else if (m_k == 0) begin
            if (start) begin
                m_k      <= 1;
                m_n      <= shifts_for(exp_a, exp_b);
                m_sel    <= (exp_a >= exp_b);
                m_exp    <= (exp_a >= exp_b) ? exp_a : exp_b;
                m_f      <= ((exp_a >= exp_b) ? exp_b : exp_a) != 8'h00;
                m_sticky <= 1'b0;
            end
        end else if (abort) begin
            m_k      <= 0;
            m_sticky <= 1'b0;
        end else begin
            if (STICKY_EN && m_k >= 2 && m_k <= m_n + 1) m_sticky <= m_sticky | sr_lsb;
            m_k <= (m_k + 1 > m_n + 2) ? 0 : m_k + 1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (run_chk) begin
            chk("load",    32'(load),    32'((m_k == 1) && !abort));
            chk("shift",   32'(shift),   32'((m_k >= 2) && (m_k <= m_n + 1) && !abort));
            chk("done",    32'(done),    32'((m_k != 0) && (m_k == m_n + 2) && !abort));
            chk("clear",   32'(clear),   32'((m_k != 0) && abort));
            chk("busy",    32'(busy),    32'(m_k != 0));
            chk("sel",     32'(sel),     32'(m_sel));
            chk("f_bit",   32'(f_bit),   32'(m_f));
            chk("exp_res", 32'(exp_res), 32'(m_exp));
            chk("sticky",  32'(sticky),  32'(m_sticky));
            chk("onehot",  32'((int'(load) + int'(shift) + int'(clear)) <= 1), 32'd1);
        end
    end

    // One transaction, called at a drive point (just after a rising edge).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int abort_k,
                          input bit hold_start, input logic [31:0] pat,
                          output int lat, output logic [7:0] r_exp, output logic r_sticky,
                          output logic r_sel, output logic r_clear, output logic r_busy_after);
        bit aborted;
        aborted = 1'b0;
        lat = -1; r_exp = 8'hxx; r_sticky = 1'bx; r_sel = 1'bx; r_clear = 1'b0; r_busy_after = 1'b1;
        exp_a = a; exp_b = b; start = 1'b1; abort = 1'b0; sr_lsb = 1'b0;
        @(posedge clk); #1;
        for (int k = 1; k <= 40; k++) begin
            start  = hold_start && !aborted;
            abort  = (k == abort_k);
            sr_lsb = (k < 32) ? pat[k] : 1'b0;
            @(negedge clk);
            if (k == abort_k) r_clear = clear;
            if (abort_k > 0 && k == abort_k + 1) r_busy_after = busy;
            if (done && lat < 0) begin
                lat = k; r_exp = exp_res; r_sticky = sticky; r_sel = sel;
            end
            @(posedge clk); #1;
            if (k == abort_k) aborted = 1'b1;
            if (lat >= 0) break;
            if (abort_k > 0 && k >= abort_k + 4) break;
        end
        if (abort_k == 0 && lat < 0) begin
            failures++; checks++;
            $display("FAIL timeout no done within 40 cycles for a=%0h b=%0h", a, b);
        end
        start = 1'b0; abort = 1'b0; sr_lsb = 1'b0;
    endtask

    int         lat;
    logic [7:0] r_exp;
    logic       r_sticky, r_sel, r_clear, r_busy_after;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        run_chk = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_exp_res", 32'(exp_res), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Scenario 1: three shifts, B loaded.
        run_op(8'h85, 8'h82, 0, 1'b0, 32'h0, lat, r_exp, r_sticky, r_sel, r_clear, r_busy_after);
        chk("s1_latency", 32'(lat), 32'd5);
        chk("s1_exp_res", 32'(r_exp), 32'h85);
        chk("s1_sel", 32'(r_sel), 32'd1);

        // Scenario 2: equal exponents, no shifts.
        run_op(8'h7F, 8'h7F, 0, 1'b0, 32'hFFFF_FFFF, lat, r_exp, r_sticky, r_sel, r_clear, r_busy_after);
        chk("s2_latency", 32'(lat), 32'd2);
        chk("s2_sticky", 32'(r_sticky), 32'd0);
        chk("s2_sel", 32'(r_sel), 32'd1);

        // Scenario 3: saturated 24 shifts, A loaded.
        run_op(8'h10, 8'hF0, 0, 1'b0, 32'h0, lat, r_exp, r_sticky, r_sel, r_clear, r_busy_after);
        chk("s3_latency", 32'(lat), 32'd26);
        chk("s3_exp_res", 32'(r_exp), 32'hF0);
        chk("s3_sel", 32'(r_sel), 32'd0);

        // Scenario 4: one set bit on the second of three shifts.
        run_op(8'h83, 8'h80, 0, 1'b0, 32'h0000_0008, lat, r_exp, r_sticky, r_sel, r_clear, r_busy_after);
        chk("s4_latency", 32'(lat), 32'd5);
        chk("s4_sticky", 32'(r_sticky), 32'(STICKY_EN));

        // Scenario 5: abort on the second shift, start held while busy.
        run_op(8'h85, 8'h82, 3, 1'b1, 32'hFFFF_FFFF, lat, r_exp, r_sticky, r_sel, r_clear, r_busy_after);
        chk("s5_no_done", 32'(lat), 32'hFFFF_FFFF);
        chk("s5_clear", 32'(r_clear), 32'd1);
        chk("s5_busy_after", 32'(r_busy_after), 32'd0);
        chk("s5_sticky", 32'(sticky), 32'd0);

        // Scenario 6: reset in the middle of shifting.
        exp_a = 8'h90; exp_b = 8'h80; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; sr_lsb = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("s6_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_outs", 32'({sel, f_bit, load, shift, clear, busy, done, sticky}), 32'd0);
        chk("s6_rst_exp", 32'(exp_res), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1; sr_lsb = 1'b0;
        run_op(8'h85, 8'h82, 0, 1'b0, 32'h0, lat, r_exp, r_sticky, r_sel, r_clear, r_busy_after);
        chk("s6_latency", 32'(lat), 32'd5);
        chk("s6_exp_res", 32'(r_exp), 32'h85);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            int mode;
            mode   = int'($urandom_range(0, 3));
            start  = ($urandom_range(0, 3) == 0);
            abort  = ($urandom_range(0, 24) == 0);
            sr_lsb = 1'($urandom_range(0, 1));
            exp_a  = 8'($urandom);
            case (mode)
                0: exp_b = 8'($urandom);
                1: exp_b = exp_a + 8'($urandom_range(0, 6)) - 8'd3;
                2: exp_b = 8'h00;
                default: exp_b = exp_a ^ 8'($urandom_range(0, 31));
            endcase
            if (c % 900 == 450) begin
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        run_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
